// File: rtl/muldiv_if.sv
// Start/done handshake bundle between the CPU control FSM and the iterative
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) and divide (restoring) unit.
// Works on magnitudes, then sign-corrects into HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic               accept, iterate, load_result, finish;
    logic               op_q, sign_a, sign_b;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic               busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               b_zero;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;

    assign mag_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign mag_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign b_zero = (bus.b == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = (bus.op && b_zero) ? DONE : RUN;
            RUN:  if (count == LAST) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        iterate     = 1'b0;
        load_result = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: accept      = bus.start;
            RUN:  iterate     = 1'b1;
            FIX:  load_result = 1'b1;
            DONE: finish      = 1'b1;
            default: ;
        endcase
    end

    // acc holds {upper, multiplier} for mult and {remainder, quotient} for div
    always_comb begin
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        div_shift = {acc[2*WIDTH-2:0], 1'b0};
        div_diff  = {1'b0, div_shift[2*WIDTH-1:WIDTH]} - {1'b0, operand};
        acc_next  = acc;
        if (!op_q) begin
            if (acc[0]) acc_next = {mult_sum, acc[WIDTH-1:1]};
            else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            if (!div_diff[WIDTH]) acc_next = {div_diff[WIDTH-1:0], div_shift[WIDTH-1:1], 1'b1};
            else                  acc_next = div_shift;
        end
    end

    // Quotient follows sign(a)^sign(b); remainder follows the dividend
    always_comb begin
        product   = (sign_a ^ sign_b) ? -acc : acc;
        quotient  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remainder = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            count   <= '0;
            operand <= '0;
            acc     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q    <= bus.op;
                sign_a  <= bus.a[WIDTH-1];
                sign_b  <= bus.b[WIDTH-1];
                count   <= '0;
                busy_q  <= 1'b1;
                dbz_q   <= bus.op && b_zero;
                operand <= bus.op ? mag_b : mag_a;
                acc     <= {{WIDTH{1'b0}}, (bus.op ? mag_a : mag_b)};
            end
            if (iterate) begin
                count <= count + 1'b1;
                acc   <= acc_next;
            end
            if (load_result) begin
                if (op_q) begin
                    hi_q <= remainder;
                    lo_q <= quotient;
                end else begin
                    hi_q <= product[2*WIDTH-1:WIDTH];
                    lo_q <= product[WIDTH-1:0];
                end
            end
            // done is registered, so it rises as the FSM returns to IDLE
            if (finish) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed results, divide-by-zero,
// ignored re-start and mid-operation reset.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    muldiv_if #(.WIDTH(WIDTH)) mif ();

    muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulses start at a negedge and waits for done; lat is the accepting-edge-relative
    // edge after which done was seen. A second start can be pulsed after edge repulse_at.
    task automatic apply_stimulus(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  input int repulse_at, output int lat, output logic busy_ok);
        int n;
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        @(posedge clk);
        n = 0;
        busy_ok = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        mif.a     = 32'hDEAD_BEEF;
        mif.b     = 32'h0000_0000;
        while (!mif.done && n < 60) begin
            if (!mif.busy) busy_ok = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == repulse_at) begin
                mif.start = 1'b1;
                mif.op    = 1'b0;
                mif.a     = 32'd9;
                mif.b     = 32'd9;
            end else begin
                mif.start = 1'b0;
            end
        end
        if (mif.busy) busy_ok = 1'b0;
        lat = n;
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic saw_done;

        mif.start = 1'b0;
        mif.op    = 1'b0;
        mif.a     = '0;
        mif.b     = '0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", {63'd0, mif.busy}, 64'd0);
        check_output("reset_done", {63'd0, mif.done}, 64'd0);
        check_output("reset_hilo", {mif.hi, mif.lo}, 64'd0);
        check_output("reset_dbz", {63'd0, mif.div_by_zero}, 64'd0);
        reset = 1'b1;

        apply_stimulus(1'b0, 32'd7, 32'hFFFF_FFFD, -1, lat, busy_ok);
        check_output("mul_7x-3_lat", lat, 34);
        check_output("mul_7x-3_busy", {63'd0, busy_ok}, 64'd1);
        check_output("mul_7x-3_hi", mif.hi, 32'hFFFF_FFFF);
        check_output("mul_7x-3_lo", mif.lo, 32'hFFFF_FFEB);
        @(negedge clk);
        check_output("done_pulse_width", {63'd0, mif.done}, 64'd0);

        apply_stimulus(1'b1, 32'hFFFF_FFEF, 32'd5, -1, lat, busy_ok);
        check_output("div_-17/5_lat", lat, 34);
        check_output("div_-17/5_lo", mif.lo, 32'hFFFF_FFFD);
        check_output("div_-17/5_hi", mif.hi, 32'hFFFF_FFFE);
        check_output("div_-17/5_dbz", {63'd0, mif.div_by_zero}, 64'd0);

        apply_stimulus(1'b0, 32'd6, 32'd7, -1, lat, busy_ok);
        check_output("mul_6x7_hilo", {mif.hi, mif.lo}, {32'd0, 32'd42});

        apply_stimulus(1'b1, 32'd10, 32'd0, -1, lat, busy_ok);
        check_output("dbz_lat", lat, 1);
        check_output("dbz_busy", {63'd0, busy_ok}, 64'd1);
        check_output("dbz_flag", {63'd0, mif.div_by_zero}, 64'd1);
        check_output("dbz_hilo_kept", {mif.hi, mif.lo}, {32'd0, 32'd42});

        apply_stimulus(1'b0, 32'd1, 32'd1, -1, lat, busy_ok);
        check_output("dbz_cleared", {63'd0, mif.div_by_zero}, 64'd0);
        check_output("mul_1x1_lo", mif.lo, 32'd1);

        apply_stimulus(1'b0, 32'h8000_0000, 32'h8000_0000, -1, lat, busy_ok);
        check_output("mul_min_x_min", {mif.hi, mif.lo}, {32'h4000_0000, 32'd0});

        apply_stimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, busy_ok);
        check_output("div_min/-1", {mif.hi, mif.lo}, {32'd0, 32'h8000_0000});

        apply_stimulus(1'b1, 32'd5, 32'd7, -1, lat, busy_ok);
        check_output("div_5/7", {mif.hi, mif.lo}, {32'd5, 32'd0});

        apply_stimulus(1'b1, 32'd100, 32'd3, 5, lat, busy_ok);
        check_output("div_100/3_lat", lat, 34);
        check_output("div_100/3_busy", {63'd0, busy_ok}, 64'd1);
        check_output("div_100/3_result", {mif.hi, mif.lo}, {32'd1, 32'd33});

        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = 1'b0;
        mif.a     = 32'd3;
        mif.b     = 32'd4;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (9) @(negedge clk);
        check_output("pre_reset_busy", {63'd0, mif.busy}, 64'd1);
        reset = 1'b0;
        #1;
        check_output("abort_busy", {63'd0, mif.busy}, 64'd0);
        check_output("abort_done", {63'd0, mif.done}, 64'd0);
        check_output("abort_hilo", {mif.hi, mif.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done) saw_done = 1'b1;
        end
        check_output("no_done_after_abort", {63'd0, saw_done}, 64'd0);
        check_output("idle_after_abort", {63'd0, mif.busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
